// File: rtl/ex_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_operand_stage_pkg
// Shared pipeline definitions for the ID/EX operand stage:
//   - data / register-number / opcode widths
//   - ALU operation encoding
//   - forwarding-select encoding
//   - the ID/EX pipeline register layout
// ---------------------------------------------------------------------------
package ex_operand_stage_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int OP_W    = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SLL = 4'd3,
        ALU_SRL = 4'd4,
        ALU_SRA = 4'd5,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_XOR = 4'd8,
        ALU_NOR = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_EXM = 2'b10
    } fwd_sel_e;

    // ID/EX register contents; an all-zero value is a bubble.
    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
        logic [DATA_W-1:0]  imm;
        logic [SHAMT_W-1:0] shamt;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   dest;
        logic [OP_W-1:0]    alu_op;
        logic               alu_src;
        logic               shamt_sel;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
    } id_ex_t;

    // EX/MEM beats MEM/WB because it holds the younger result.
    // Register 0 is hardwired, so it is never forwarded.
    function automatic fwd_sel_e fwd_pick(
        input logic [REG_W-1:0] src,
        input logic             exm_we,
        input logic [REG_W-1:0] exm_dest,
        input logic             wb_we,
        input logic [REG_W-1:0] wb_dest
    );
        if (exm_we && (exm_dest != '0) && (exm_dest == src))
            return FWD_EXM;
        else if (wb_we && (wb_dest != '0) && (wb_dest == src))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
// Forwarding-select logic for both ALU source operands.
// Ports:
//   i_rs, i_rt          registered source register numbers
//   i_exm_reg_write/dest EX/MEM writer
//   i_wb_reg_write/dest  MEM/WB writer
//   o_sel_a, o_sel_b     00 register file, 01 MEM/WB, 10 EX/MEM
// ---------------------------------------------------------------------------
module fwd_unit
    import ex_operand_stage_pkg::*;
(
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rt,
    input  logic             i_exm_reg_write,
    input  logic [REG_W-1:0] i_exm_dest,
    input  logic             i_wb_reg_write,
    input  logic [REG_W-1:0] i_wb_dest,
    output fwd_sel_e         o_sel_a,
    output fwd_sel_e         o_sel_b
);

    assign o_sel_a = fwd_pick(i_rs, i_exm_reg_write, i_exm_dest, i_wb_reg_write, i_wb_dest);
    assign o_sel_b = fwd_pick(i_rt, i_exm_reg_write, i_exm_dest, i_wb_reg_write, i_wb_dest);

endmodule

// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
// ID/EX pipeline register plus operand forwarding and source selection.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   i_stall, i_flush       hold registers / load a bubble (flush wins)
//   i_valid ... i_mem_write ID-stage instruction fields
//   i_exm_*, i_wb_*        forwarding sources from EX/MEM and MEM/WB
//   o_data_a, o_data_b     ALU operands
//   o_operation            ALU opcode
//   o_store_data, o_dest, o_reg_write, o_mem_read, o_mem_write, o_valid
// ---------------------------------------------------------------------------
module ex_operand_stage
    import ex_operand_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [DATA_W-1:0]  i_rs_data,
    input  logic [DATA_W-1:0]  i_rt_data,
    input  logic [DATA_W-1:0]  i_imm,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [REG_W-1:0]   i_rs,
    input  logic [REG_W-1:0]   i_rt,
    input  logic [REG_W-1:0]   i_dest,
    input  logic [OP_W-1:0]    i_alu_op,
    input  logic               i_alu_src,
    input  logic               i_shamt_sel,
    input  logic               i_reg_write,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic               i_exm_reg_write,
    input  logic [REG_W-1:0]   i_exm_dest,
    input  logic [DATA_W-1:0]  i_exm_data,
    input  logic               i_wb_reg_write,
    input  logic [REG_W-1:0]   i_wb_dest,
    input  logic [DATA_W-1:0]  i_wb_data,
    output logic [DATA_W-1:0]  o_data_a,
    output logic [DATA_W-1:0]  o_data_b,
    output logic [OP_W-1:0]    o_operation,
    output logic [DATA_W-1:0]  o_store_data,
    output logic [REG_W-1:0]   o_dest,
    output logic               o_reg_write,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_valid
);

    id_ex_t            r_q;
    id_ex_t            w_id;
    fwd_sel_e          w_sel_a;
    fwd_sel_e          w_sel_b;
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;

    assign w_id = '{
        valid:     i_valid,
        rs_data:   i_rs_data,
        rt_data:   i_rt_data,
        imm:       i_imm,
        shamt:     i_shamt,
        rs:        i_rs,
        rt:        i_rt,
        dest:      i_dest,
        alu_op:    i_alu_op,
        alu_src:   i_alu_src,
        shamt_sel: i_shamt_sel,
        reg_write: i_reg_write,
        mem_read:  i_mem_read,
        mem_write: i_mem_write
    };

    // Bubble is the all-zero record, so flush and reset share one encoding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else if (i_flush)
            r_q <= '0;
        else if (!i_stall)
            r_q <= w_id;
    end

    // Selects track the live EX/MEM and MEM/WB state, so a stalled
    // instruction picks up results that retire while it waits.
    fwd_unit u_fwd (
        .i_rs            (r_q.rs),
        .i_rt            (r_q.rt),
        .i_exm_reg_write (i_exm_reg_write),
        .i_exm_dest      (i_exm_dest),
        .i_wb_reg_write  (i_wb_reg_write),
        .i_wb_dest       (i_wb_dest),
        .o_sel_a         (w_sel_a),
        .o_sel_b         (w_sel_b)
    );

    always_comb begin
        w_fwd_a = r_q.rs_data;
        case (w_sel_a)
            FWD_EXM: w_fwd_a = i_exm_data;
            FWD_WB:  w_fwd_a = i_wb_data;
            default: w_fwd_a = r_q.rs_data;
        endcase
    end

    always_comb begin
        w_fwd_b = r_q.rt_data;
        case (w_sel_b)
            FWD_EXM: w_fwd_b = i_exm_data;
            FWD_WB:  w_fwd_b = i_wb_data;
            default: w_fwd_b = r_q.rt_data;
        endcase
    end

    assign o_data_a     = r_q.shamt_sel ? {{(DATA_W-SHAMT_W){1'b0}}, r_q.shamt} : w_fwd_a;
    assign o_data_b     = r_q.alu_src ? r_q.imm : w_fwd_b;
    // Stores always need the rt register value, even when B is the immediate.
    assign o_store_data = w_fwd_b;
    assign o_operation  = r_q.alu_op;
    assign o_dest       = r_q.dest;
    assign o_reg_write  = r_q.reg_write;
    assign o_mem_read   = r_q.mem_read;
    assign o_mem_write  = r_q.mem_write;
    assign o_valid      = r_q.valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    logic        clk, rst_n, i_stall, i_flush, i_valid;
    logic [31:0] i_rs_data, i_rt_data, i_imm;
    logic [4:0]  i_shamt, i_rs, i_rt, i_dest;
    logic [3:0]  i_alu_op;
    logic        i_alu_src, i_shamt_sel, i_reg_write, i_mem_read, i_mem_write;
    logic        i_exm_reg_write, i_wb_reg_write;
    logic [4:0]  i_exm_dest, i_wb_dest;
    logic [31:0] i_exm_data, i_wb_data;
    logic [31:0] o_data_a, o_data_b, o_store_data;
    logic [3:0]  o_operation;
    logic [4:0]  o_dest;
    logic        o_reg_write, o_mem_read, o_mem_write, o_valid;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .i_stall(i_stall), .i_flush(i_flush),
        .i_valid(i_valid), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
        .i_imm(i_imm), .i_shamt(i_shamt), .i_rs(i_rs), .i_rt(i_rt),
        .i_dest(i_dest), .i_alu_op(i_alu_op), .i_alu_src(i_alu_src),
        .i_shamt_sel(i_shamt_sel), .i_reg_write(i_reg_write),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_exm_reg_write(i_exm_reg_write), .i_exm_dest(i_exm_dest),
        .i_exm_data(i_exm_data), .i_wb_reg_write(i_wb_reg_write),
        .i_wb_dest(i_wb_dest), .i_wb_data(i_wb_data),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_operation(o_operation),
        .o_store_data(o_store_data), .o_dest(o_dest),
        .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_valid(o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference: the instruction the stage is currently presenting to EX.
    typedef struct {
        logic        valid, alu_src, shamt_sel, reg_write, mem_read, mem_write;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  shamt, rs, rt, dest;
        logic [3:0]  alu_op;
    } instr_t;
    instr_t m;

    function automatic instr_t bubble();
        instr_t b;
        b = '{valid: 1'b0, alu_src: 1'b0, shamt_sel: 1'b0, reg_write: 1'b0,
              mem_read: 1'b0, mem_write: 1'b0, rs_data: 32'h0, rt_data: 32'h0,
              imm: 32'h0, shamt: 5'h0, rs: 5'h0, rt: 5'h0, dest: 5'h0, alu_op: 4'h0};
        return b;
    endfunction

    // Architectural value of register r as EX should see it right now.
    function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] file_val);
        if (r == 5'd0)                                   return file_val;
        if (i_exm_reg_write && i_exm_dest == r)          return i_exm_data;
        if (i_wb_reg_write && i_wb_dest == r)            return i_wb_data;
        return file_val;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] a, b, st;
        st = reg_value(m.rt, m.rt_data);
        a  = m.shamt_sel ? 32'(m.shamt) : reg_value(m.rs, m.rs_data);
        b  = m.alu_src ? m.imm : st;
        chk({tag, ".data_a"},     o_data_a, a);
        chk({tag, ".data_b"},     o_data_b, b);
        chk({tag, ".store"},      o_store_data, st);
        chk({tag, ".op"},         32'(o_operation), 32'(m.alu_op));
        chk({tag, ".dest"},       32'(o_dest), 32'(m.dest));
        chk({tag, ".reg_write"},  32'(o_reg_write), 32'(m.reg_write));
        chk({tag, ".mem_read"},   32'(o_mem_read), 32'(m.mem_read));
        chk({tag, ".mem_write"},  32'(o_mem_write), 32'(m.mem_write));
        chk({tag, ".valid"},      32'(o_valid), 32'(m.valid));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".data_a"}, o_data_a, 32'h0);
        chk({tag, ".data_b"}, o_data_b, 32'h0);
        chk({tag, ".store"},  o_store_data, 32'h0);
        chk({tag, ".ctl"}, {19'h0, o_operation, o_dest, o_reg_write, o_mem_read, o_mem_write, o_valid}, 32'h0);
    endtask

    // One clock: the model takes what the stage should take at this edge.
    task automatic step();
        if (rst_n) begin
            if (i_flush) m = bubble();
            else if (!i_stall)
                m = '{valid: i_valid, alu_src: i_alu_src, shamt_sel: i_shamt_sel,
                      reg_write: i_reg_write, mem_read: i_mem_read, mem_write: i_mem_write,
                      rs_data: i_rs_data, rt_data: i_rt_data, imm: i_imm, shamt: i_shamt,
                      rs: i_rs, rt: i_rt, dest: i_dest, alu_op: i_alu_op};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        i_valid = 0; i_rs_data = 0; i_rt_data = 0; i_imm = 0; i_shamt = 0;
        i_rs = 0; i_rt = 0; i_dest = 0; i_alu_op = 0; i_alu_src = 0;
        i_shamt_sel = 0; i_reg_write = 0; i_mem_read = 0; i_mem_write = 0;
        i_exm_reg_write = 0; i_exm_dest = 0; i_exm_data = 0;
        i_wb_reg_write = 0; i_wb_dest = 0; i_wb_data = 0;
    endtask

    task automatic randomize_id();
        i_valid = 1'($urandom); i_rs_data = $urandom; i_rt_data = $urandom;
        i_imm = $urandom; i_shamt = 5'($urandom); i_rs = 5'($urandom_range(0, 7));
        i_rt = 5'($urandom_range(0, 7)); i_dest = 5'($urandom); i_alu_op = 4'($urandom);
        i_alu_src = 1'($urandom); i_shamt_sel = 1'($urandom);
        i_reg_write = 1'($urandom); i_mem_read = 1'($urandom); i_mem_write = 1'($urandom);
    endtask

    task automatic randomize_fwd();
        i_exm_reg_write = 1'($urandom); i_exm_dest = 5'($urandom_range(0, 7)); i_exm_data = $urandom;
        i_wb_reg_write = 1'($urandom);  i_wb_dest = 5'($urandom_range(0, 7));  i_wb_data = $urandom;
    endtask

    initial begin
        m = bubble();
        rst_n = 0; i_stall = 0; i_flush = 0;
        clear_id();
        // Reset with nonzero ID inputs: nothing is captured.
        randomize_id(); i_valid = 1;
        step(); step();
        check_zero("reset_hold");
        rst_n = 1;

        // Plain capture, no forwarding.
        clear_id();
        i_valid = 1; i_rs = 5'd1; i_rt = 5'd2; i_rs_data = 32'd5; i_rt_data = 32'd7;
        i_alu_op = ALU_ADD; i_reg_write = 1; i_dest = 5'd9;
        step();
        chk("capture.a", o_data_a, 32'd5);
        chk("capture.b", o_data_b, 32'd7);
        chk("capture.op", 32'(o_operation), 32'(ALU_ADD));
        check_model("capture");

        // EX/MEM has priority over MEM/WB.
        i_rs = 5'd3; i_rs_data = 32'h11;
        i_exm_reg_write = 1; i_exm_dest = 5'd3; i_exm_data = 32'hAA;
        i_wb_reg_write = 1;  i_wb_dest = 5'd3;  i_wb_data = 32'hBB;
        step();
        chk("fwd_exm", o_data_a, 32'hAA);
        i_exm_reg_write = 0; #1;
        chk("fwd_wb", o_data_a, 32'hBB);
        check_model("fwd");

        // $0 is never forwarded.
        clear_id();
        i_valid = 1; i_rs = 5'd0; i_rs_data = 32'h33;
        i_exm_reg_write = 1; i_exm_dest = 5'd0; i_exm_data = 32'hFF;
        i_wb_reg_write = 1;  i_wb_dest = 5'd0;  i_wb_data = 32'hEE;
        step();
        chk("zero_reg", o_data_a, 32'h33);

        // Shift amount as A, immediate as B, store data still forwarded rt.
        clear_id();
        i_valid = 1; i_shamt_sel = 1; i_shamt = 5'd4; i_alu_src = 1; i_imm = 32'hFFFF_FFF0;
        i_rs = 5'd6; i_rs_data = 32'h77; i_rt = 5'd5; i_rt_data = 32'h1234;
        i_alu_op = ALU_SLL; i_mem_write = 1;
        i_wb_reg_write = 1; i_wb_dest = 5'd5; i_wb_data = 32'h5555;
        step();
        chk("shimm.a", o_data_a, 32'd4);
        chk("shimm.b", o_data_b, 32'hFFFF_FFF0);
        chk("shimm.store", o_store_data, 32'h5555);
        check_model("shimm");

        // Stall two cycles with new ID inputs: outputs hold.
        i_stall = 1;
        randomize_id();
        step();
        chk("stall1.a", o_data_a, 32'd4);
        chk("stall1.store", o_store_data, 32'h5555);
        step();
        chk("stall2.b", o_data_b, 32'hFFFF_FFF0);
        check_model("stall2");
        // Forwarding still tracks live sources during the stall.
        i_exm_reg_write = 1; i_exm_dest = 5'd5; i_exm_data = 32'hCAFE; #1;
        chk("stall_fwd.store", o_store_data, 32'hCAFE);

        // Flush beats stall.
        i_flush = 1;
        step();
        chk("flush.valid", 32'(o_valid), 32'h0);
        chk("flush.reg_write", 32'(o_reg_write), 32'h0);
        check_model("flush");
        i_flush = 0; i_stall = 0;

        // Randomized run against the reference.
        for (int n = 0; n < 300; n++) begin
            randomize_id();
            randomize_fwd();
            i_stall = ($urandom_range(0, 3) == 0);
            i_flush = ($urandom_range(0, 7) == 0);
            step();
            check_model("rand");
            randomize_fwd(); #1;
            check_model("rand_fwd");
        end

        // Asynchronous reset mid-stall, between clock edges.
        i_flush = 0; i_stall = 0;
        randomize_id(); i_valid = 1; i_reg_write = 1;
        step();
        i_stall = 1;
        #2 rst_n = 0;
        m = bubble();
        #1;
        check_zero("async_reset");
        i_flush = 1;
        step();
        check_zero("reset_ignores_ctl");
        rst_n = 1; i_flush = 0; i_stall = 0;
        clear_id();
        i_valid = 1; i_rs_data = 32'hDEAD_BEEF; i_rs = 5'd4; i_alu_op = ALU_SUB;
        step();
        chk("post_reset.a", o_data_a, 32'hDEAD_BEEF);
        check_model("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
